pwd_verify_ctrl: RTL and testbench

Password entry and verification controller for the FPGA password lock. Collects debounced keypad codes and compares the entered code with the stored password. Maintains the wrong-attempt count, enforces lockout, and supports password change. It sits directly upstream of the LED warning stage: its error_count, start_count4 and start_count5 outputs drive that block's error-flash and unattended-entry LEDs.

---
 rtl/pwd_verify_ctrl_if.sv | 19 +
 rtl/pwd_verify_ctrl.sv | 129 ++++++++++++
 tb/tb_pwd_verify_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pwd_verify_ctrl_if.sv
// pwd_verify_ctrl_if: keypad strobe in, lock status and warning-stage enables out.
interface pwd_verify_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] error_count;
  logic        start_count4;
  logic        start_count5;
  logic        unlock;
  logic        locked;
  logic [2:0]  digit_cnt;
  modport master (
    output key_valid, key_code,
    input  error_count, start_count4, start_count5, unlock, locked, digit_cnt
  );
  modport slave (
    input  key_valid, key_code,
    output error_count, start_count4, start_count5, unlock, locked, digit_cnt
  );
endinterface

// File: rtl/pwd_verify_ctrl.sv
// pwd_verify_ctrl: password entry, check, lockout and change for the keypad lock.
// Optional entry inactivity timeout enabled by defining PWD_ENTRY_TIMEOUT_EN.
module pwd_verify_ctrl #(
  parameter int DIGITS = 4,
  parameter logic [DIGITS*4-1:0] DEFAULT_PWD = 16'h1234,
  parameter int CLK_HZ = 50_000_000,
  parameter int UNLOCK_S = 5,
  parameter int LOCK_ERRS = 3,
  parameter int LOCK_S = 30,
  parameter int ENTRY_TO_S = 60
) (
  input logic clk,
  input logic rst_n,
  pwd_verify_ctrl_if.slave bus
);
  localparam int W = DIGITS * 4;
  localparam logic [63:0] UNLOCK_CYC = 64'(UNLOCK_S) * 64'(CLK_HZ);
  localparam logic [63:0] LOCK_CYC = 64'(LOCK_S) * 64'(CLK_HZ);
  localparam logic [2:0] IDLE = 3'd0, ENTRY = 3'd1, CHECK = 3'd2,
                         UNLOCKED = 3'd3, SETPWD = 3'd4, LOCKOUT = 3'd5;
  logic [2:0] state;
  logic [W-1:0] entry, pwd;
  logic [31:0] tmr;
  logic is_digit, is_clr, is_ent, is_chg, full, take_digit;
  logic [31:0] err_inc;
`ifdef PWD_ENTRY_TIMEOUT_EN
  localparam logic [63:0] ENT_CYC = 64'(ENTRY_TO_S) * 64'(CLK_HZ);
  logic [31:0] ent_tmr;
`endif
  always_comb begin
    is_digit = bus.key_valid && bus.key_code <= 4'd9;
    is_clr = bus.key_valid && bus.key_code == 4'hA;
    is_ent = bus.key_valid && bus.key_code == 4'hB;
    is_chg = bus.key_valid && bus.key_code == 4'hC;
    full = bus.digit_cnt == 3'(DIGITS);
    take_digit = is_digit && !full && (state == IDLE || state == ENTRY || state == SETPWD);
    err_inc = &bus.error_count ? bus.error_count : bus.error_count + 32'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      entry <= '0;
      pwd <= DEFAULT_PWD;
      tmr <= '0;
      bus.error_count <= '0;
      bus.start_count4 <= 1'b0;
      bus.start_count5 <= 1'b0;
      bus.unlock <= 1'b0;
      bus.locked <= 1'b0;
      bus.digit_cnt <= '0;
`ifdef PWD_ENTRY_TIMEOUT_EN
      ent_tmr <= '0;
`endif
    end else begin
      bus.start_count4 <= bus.error_count != 0;
      bus.start_count5 <= state == ENTRY || state == SETPWD;
      if (take_digit) begin
        entry <= {entry[W-5:0], bus.key_code};
        bus.digit_cnt <= bus.digit_cnt + 3'd1;
      end
      case (state)
        IDLE: begin
          if (is_digit) state <= ENTRY;
          else if (is_ent) state <= CHECK;
`ifdef PWD_ENTRY_TIMEOUT_EN
          ent_tmr <= ENT_CYC[31:0];
`endif
        end
        ENTRY: begin
          if (is_clr) begin
            entry <= '0;
            bus.digit_cnt <= '0;
            state <= IDLE;
          end else if (is_ent) state <= CHECK;
`ifdef PWD_ENTRY_TIMEOUT_EN
          if (bus.key_valid) ent_tmr <= ENT_CYC[31:0];
          else if (ent_tmr <= 32'd1) begin
            entry <= '0;
            bus.digit_cnt <= '0;
            state <= IDLE;
          end else ent_tmr <= ent_tmr - 32'd1;
`endif
        end
        CHECK: begin
          entry <= '0;
          bus.digit_cnt <= '0;
          if (full && entry == pwd) begin
            bus.error_count <= '0;
            bus.unlock <= 1'b1;
            tmr <= UNLOCK_CYC[31:0];
            state <= UNLOCKED;
          end else begin
            bus.error_count <= err_inc;
            if (err_inc >= 32'(LOCK_ERRS)) begin
              bus.locked <= 1'b1;
              tmr <= LOCK_CYC[31:0];
              state <= LOCKOUT;
            end else state <= IDLE;
          end
        end
        UNLOCKED: begin
          // Expiry wins over a key arriving in the same cycle.
          if (tmr <= 32'd1 || is_clr) begin
            bus.unlock <= 1'b0;
            state <= IDLE;
          end else begin
            tmr <= tmr - 32'd1;
            if (is_chg) state <= SETPWD;
          end
        end
        SETPWD: begin
          if (is_clr || is_ent) begin
            if (is_ent && full) pwd <= entry;
            entry <= '0;
            bus.digit_cnt <= '0;
            tmr <= UNLOCK_CYC[31:0];
            state <= UNLOCKED;
          end
        end
        LOCKOUT: begin
          if (tmr <= 32'd1) begin
            bus.locked <= 1'b0;
            state <= IDLE;
          end else tmr <= tmr - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pwd_verify_ctrl.sv
// tb_pwd_verify_ctrl: directed keypad sequences against hand-computed lock responses.
module tb_pwd_verify_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  pwd_verify_ctrl_if bus();
  pwd_verify_ctrl #(.CLK_HZ(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic key(input logic [3:0] c);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask
  task automatic code4(input logic [15:0] c);
    for (int i = 0; i < 4; i++) key(c[15-4*i -: 4]);
  endtask
  task automatic try4(input logic [15:0] c);
    code4(c);
    key(4'hB);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_err", bus.error_count, 0);
    chk("rst_sc4", 32'(bus.start_count4), 0);
    chk("rst_sc5", 32'(bus.start_count5), 0);
    chk("rst_unlock", 32'(bus.unlock), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_dcnt", 32'(bus.digit_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    repeat (2) @(negedge clk);
    do_reset();
    // correct entry, unlock held exactly 50 cycles
    code4(16'h1234);
    chk("t1_dcnt", 32'(bus.digit_cnt), 4);
    key(4'hB);
    chk("t1_unlock_latency", 32'(bus.unlock), 0);
    @(negedge clk);
    chk("t1_unlock", 32'(bus.unlock), 1);
    repeat (49) @(negedge clk);
    chk("t1_unlock_last", 32'(bus.unlock), 1);
    @(negedge clk);
    chk("t1_unlock_end", 32'(bus.unlock), 0);
    chk("t1_err", bus.error_count, 0);
    // wrong entries then correct clears count
    try4(16'h1235);
    chk("t2_err1", bus.error_count, 1);
    @(negedge clk);
    chk("t2_sc4", 32'(bus.start_count4), 1);
    try4(16'h1235);
    chk("t2_err2", bus.error_count, 2);
    try4(16'h1234);
    chk("t2_err0", bus.error_count, 0);
    chk("t2_unlock", 32'(bus.unlock), 1);
    chk("t2_sc4_lag", 32'(bus.start_count4), 1);
    @(negedge clk);
    chk("t2_sc4_drop", 32'(bus.start_count4), 0);
    key(4'hA);
    chk("t2_relock", 32'(bus.unlock), 0);
    // lockout for 300 cycles, keys ignored, re-lock on next error
    try4(16'h1111);
    try4(16'h1111);
    try4(16'h1111);
    chk("t3_err3", bus.error_count, 3);
    chk("t3_locked", 32'(bus.locked), 1);
    key(4'h1);
    chk("t3_key_ignored", 32'(bus.digit_cnt), 0);
    repeat (297) @(negedge clk);
    chk("t3_locked_last", 32'(bus.locked), 1);
    @(negedge clk);
    chk("t3_lock_end", 32'(bus.locked), 0);
    try4(16'h5555);
    chk("t3_err4", bus.error_count, 4);
    chk("t3_relocked", 32'(bus.locked), 1);
    repeat (10) @(negedge clk);
    do_reset();
    // short entry and digit saturation
    key(4'h1);
    key(4'h2);
    key(4'hB);
    @(negedge clk);
    chk("t4_short_err", bus.error_count, 1);
    code4(16'h1234);
    key(4'h5);
    key(4'h6);
    chk("t4_dcnt_sat", 32'(bus.digit_cnt), 4);
    key(4'hB);
    @(negedge clk);
    chk("t4_unlock", 32'(bus.unlock), 1);
    chk("t4_err0", bus.error_count, 0);
    // password change
    key(4'hC);
    @(negedge clk);
    chk("t5_sc5", 32'(bus.start_count5), 1);
    code4(16'h9876);
    key(4'hB);
    @(negedge clk);
    chk("t5_unlock_kept", 32'(bus.unlock), 1);
    key(4'hA);
    chk("t5_relock", 32'(bus.unlock), 0);
    try4(16'h9876);
    chk("t5_new_pwd", 32'(bus.unlock), 1);
    key(4'hA);
    try4(16'h1234);
    chk("t5_old_err", bus.error_count, 1);
    chk("t5_old_locked_out", 32'(bus.unlock), 0);
    // clear from entry, then reset restores default password
    key(4'h7);
    @(negedge clk);
    chk("t6_sc5_on", 32'(bus.start_count5), 1);
    chk("t6_dcnt", 32'(bus.digit_cnt), 1);
    key(4'hA);
    @(negedge clk);
    chk("t6_sc5_off", 32'(bus.start_count5), 0);
    chk("t6_err_kept", bus.error_count, 1);
    chk("t6_dcnt_clr", 32'(bus.digit_cnt), 0);
    do_reset();
    try4(16'h1234);
    chk("t6_default_pwd", 32'(bus.unlock), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
